regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Sole driver of the register file write port (wa/wd/we).
- Merges the in-order pipeline writeback stream with results from long-latency units (divider, multicycle load) and buffers those results in a small FIFO.
- Drains buffered results into idle write slots.
- Squashes stale buffered results overtaken by younger pipeline writes (WAW), and reports pending destinations to issue logic.

Parameters:
DEPTH, 4, number of buffered long-latency results (power of two, >=2)
AW, 5, register address width (matches REG_ADDR_BUS)
DW, 32, register data width (matches REG_BUS)

Ports:
cpu_clk_50M  input  1  clock
cpu_rst_n  input  1  reset, asynchronous, active-low
p_we  input  1  pipeline writeback enable
p_wa  input  AW  pipeline destination register
p_wd  input  DW  pipeline write data
m_valid  input  1  long-latency result valid
m_wa  input  AW  long-latency destination register
m_wd  input  DW  long-latency result data
m_ready  output  1  result accepted this cycle when m_valid&&m_ready
q_addr  input  AW  issue-stage query address
q_pending  output  1  a live buffered result targets q_addr
full  output  1  FIFO holds DEPTH entries (pipeline stall request)
count  output  clog2(DEPTH)+1  occupied entries, killed entries included
we  output  1  regfile write enable, registered
wa  output  AW  regfile write address, registered
wd  output  DW  regfile write data, registered

Behaviour:
- Reset (async, cpu_rst_n=0): we=0, wa=0, wd=0, count=0, all entries invalid, read/write pointers=0. Reset asserted mid-drain discards all buffered results, with no write issued.
- Circular FIFO; each entry holds {live, wa, wd}.
- m_ready = !full. Depends only on registered count, never on the same-cycle pop.
- Push on m_valid&&m_ready:
  - m_wa==0: handshake completes, nothing stored.
  - Otherwise stored at the write pointer with live=1.
- Pipeline write is valid when p_we && p_wa!=0.
- Squash: a valid pipeline write clears live on every stored entry with wa==p_wa. An entry pushed that same cycle with m_wa==p_wa is stored with live=0. Long-latency results are always older than the current writeback instruction.
- Slot selection per cycle, registered onto we/wa/wd at the next edge (latency 1):
  1. Valid pipeline write: we=1, wa=p_wa, wd=p_wd. FIFO not popped.
  2. Else, FIFO non-empty: pop head. Head live gives we=1, wa/wd=head. Head killed gives we=0, with wa/wd holding their previous values.
  3. Else: we=0, wa/wd hold.
- Pipeline always has priority. FIFO drains only in cycles with no valid pipeline write. Starvation is resolved by issue logic stalling on full.
- Push and pop in the same cycle: count unchanged. Pointers wrap modulo DEPTH.
- full = (count==DEPTH).
- q_pending, combinational: 1 iff q_addr!=0 and some stored live entry has wa==q_addr. The entry being output this cycle counts until popped. The output register is not included, because the regfile bypasses wa==ra.

Test Plan:
- Reset with FIFO holding 3 entries, cpu_rst_n low between clock edges -> we/wa/wd/count drop to 0 immediately; no write after release.
- p_we=1 p_wa=5 p_wd=0x11 for one cycle, no m traffic -> next cycle we=1 wa=5 wd=0x11, then we=0.
- Push m_wa=3 m_wd=0xAA while p_we=1 continuous for 4 cycles -> count=1, q_pending(3)=1, no write to 3; p_we drops -> next cycle we=1 wa=3 wd=0xAA, count=0, q_pending(3)=0.
- Push 4 results (wa=1..4) with pipeline busy -> full=1, m_ready=0, a 5th m_valid is held; one idle slot -> wa=1 written, m_ready=1 the following cycle, and the held 5th result is accepted.
- Buffered entry wa=7, then pipeline write p_wa=7 wd=0x55 -> wa=7 wd=0x55 written; entry killed, q_pending(7)=0; next idle slot pops it with we=0.
- Same-cycle m_wa=9 push with p_we=1 p_wa=9 -> stored killed, count=1, q_pending(9)=0; its later pop gives we=0. Also m_wa=0 push -> m_ready=1, count unchanged.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency
// results queue in a small FIFO, drain into idle slots, and are squashed on WAW.
module regfile_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     cpu_clk_50M,
    input  logic                     cpu_rst_n,
    input  logic                     p_we,
    input  logic [AW-1:0]            p_wa,
    input  logic [DW-1:0]            p_wd,
    input  logic                     m_valid,
    input  logic [AW-1:0]            m_wa,
    input  logic [DW-1:0]            m_wd,
    output logic                     m_ready,
    input  logic [AW-1:0]            q_addr,
    output logic                     q_pending,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     we,
    output logic [AW-1:0]            wa,
    output logic [DW-1:0]            wd
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_COUNT = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE    = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [DEPTH-1:0] ent_live;
    logic [AW-1:0]   ent_wa [DEPTH];
    logic [DW-1:0]   ent_wd [DEPTH];

    logic p_valid;
    logic push;
    logic pop;
    logic head_live;

    assign p_valid   = p_we && (p_wa != '0);
    assign full      = (count == FULL_COUNT);
    assign m_ready   = !full;
    // A handshake with m_wa==0 completes but stores nothing.
    assign push      = m_valid && m_ready && (m_wa != '0);
    assign pop       = !p_valid && (count != '0);
    assign head_live = ent_live[rd_ptr];

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        q_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_live[i] && (ent_wa[i] == q_addr)) q_pending = 1'b1;
        end
        if (q_addr == '0) q_pending = 1'b0;
    end

    // Live bits double as occupancy for the pending query: cleared on pop or WAW squash.
    // NOTE: sequential state uses <= only, so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            ent_live <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((pop && (rd_ptr == PW'(i))) || (p_valid && (ent_wa[i] == p_wa)))
                    ent_live[i] <= 1'b0;
                if (push && (wr_ptr == PW'(i)))
                    ent_live[i] <= !(p_valid && (m_wa == p_wa));
            end
        end
    end

    // NOTE: payload storage is deliberately not reset; the live bits qualify it.
    always_ff @(posedge cpu_clk_50M) begin
        if (push) begin
            ent_wa[wr_ptr] <= m_wa;
            ent_wd[wr_ptr] <= m_wd;
        end
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // A killed head is consumed silently; wa/wd keep their last written values.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            we <= 1'b0;
            wa <= '0;
            wd <= '0;
        end else if (p_valid) begin
            we <= 1'b1;
            wa <= p_wa;
            wd <= p_wd;
        end else if (pop) begin
            we <= head_live;
            if (head_live) begin
                wa <= ent_wa[rd_ptr];
                wd <= ent_wd[rd_ptr];
            end
        end else begin
            we <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random
// traffic compared against a queue-based model of the writeback rules.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          cpu_clk_50M;
    logic          cpu_rst_n;
    logic          p_we;
    logic [AW-1:0] p_wa;
    logic [DW-1:0] p_wd;
    logic          m_valid;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wd;
    logic          m_ready;
    logic [AW-1:0] q_addr;
    logic          q_pending;
    logic          full;
    logic [2:0]    count;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;

    int total = 0;
    int bad   = 0;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst_n   (cpu_rst_n),
        .p_we        (p_we),
        .p_wa        (p_wa),
        .p_wd        (p_wd),
        .m_valid     (m_valid),
        .m_wa        (m_wa),
        .m_wd        (m_wd),
        .m_ready     (m_ready),
        .q_addr      (q_addr),
        .q_pending   (q_pending),
        .full        (full),
        .count       (count),
        .we          (we),
        .wa          (wa),
        .wd          (wd)
    );

    initial cpu_clk_50M = 1'b0;
    always #10 cpu_clk_50M = ~cpu_clk_50M;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reference model: ordered list of buffered results plus the expected write port.
    typedef struct {
        bit            live;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } ent_t;

    ent_t          mq[$];
    logic          exp_we;
    logic [AW-1:0] exp_wa;
    logic [DW-1:0] exp_wd;

    function automatic bit model_pending(input logic [AW-1:0] addr);
        if (addr == '0) return 1'b0;
        foreach (mq[i]) if (mq[i].live && mq[i].wa == addr) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_we = 1'b0;
        exp_wa = '0;
        exp_wd = '0;
    endtask

    task automatic set_in(input logic pwe, input logic [AW-1:0] pwa, input logic [DW-1:0] pwd,
                          input logic mv, input logic [AW-1:0] mwa, input logic [DW-1:0] mwd,
                          input logic [AW-1:0] qa);
        p_we = pwe; p_wa = pwa; p_wd = pwd;
        m_valid = mv; m_wa = mwa; m_wd = mwd;
        q_addr = qa;
    endtask

    // Advance the model by one cycle from the current inputs, then clock the DUT.
    task automatic step();
        bit   pv;
        bit   acc;
        ent_t h;
        acc = m_valid && (mq.size() < DEPTH);
        pv  = p_we && (p_wa != '0);
        if (pv) begin
            foreach (mq[i]) if (mq[i].wa == p_wa) mq[i].live = 1'b0;
            exp_we = 1'b1; exp_wa = p_wa; exp_wd = p_wd;
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            exp_we = h.live;
            if (h.live) begin exp_wa = h.wa; exp_wd = h.wd; end
        end else begin
            exp_we = 1'b0;
        end
        if (acc && m_wa != '0) begin
            h.live = !(pv && m_wa == p_wa);
            h.wa   = m_wa;
            h.wd   = m_wd;
            mq.push_back(h);
        end
        @(posedge cpu_clk_50M);
        #1;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0);
        cpu_rst_n = 1'b0;
        repeat (3) @(posedge cpu_clk_50M);
        #3;
        cpu_rst_n = 1'b1;
        model_reset();
        @(posedge cpu_clk_50M);
        #1;
    endtask

    task automatic test_reset();
        total++; if (we !== 1'b0)    begin bad++; $display("FAIL reset_we got=%0b want=0", we); end
        total++; if (wa !== '0)      begin bad++; $display("FAIL reset_wa got=%0d want=0", wa); end
        total++; if (wd !== '0)      begin bad++; $display("FAIL reset_wd got=%0h want=0", wd); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if (full !== 1'b0)  begin bad++; $display("FAIL reset_full got=%0b want=0", full); end
        total++; if (m_ready !== 1'b1) begin bad++; $display("FAIL reset_m_ready got=%0b want=1", m_ready); end
    endtask

    task automatic test_pipe_write();
        set_in(1, 5, 32'h11, 0, 0, 0, 0);
        step();
        total++; if (we !== 1'b1 || wa !== 5'd5 || wd !== 32'h11)
            begin bad++; $display("FAIL pipe_write got=%0b/%0d/%0h want=1/5/11", we, wa, wd); end
        set_in(0, 0, 0, 0, 0, 0, 0);
        step();
        total++; if (we !== 1'b0 || wa !== 5'd5 || wd !== 32'h11)
            begin bad++; $display("FAIL pipe_idle_hold got=%0b/%0d/%0h want=0/5/11", we, wa, wd); end
    endtask

    task automatic test_buffer_behind_pipe();
        set_in(1, 10, 32'h1, 1, 3, 32'hAA, 3);
        step();
        for (int k = 0; k < 3; k++) begin
            set_in(1, AW'(11 + k), 32'h2, 0, 0, 0, 3);
            step();
            total++; if (count !== 3'd1 || q_pending !== 1'b1)
                begin bad++; $display("FAIL buffered_pending got=%0d/%0b want=1/1", count, q_pending); end
            total++; if (wa === 5'd3)
                begin bad++; $display("FAIL buffered_early_write got=%0d want=not 3", wa); end
        end
        set_in(0, 0, 0, 0, 0, 0, 3);
        step();
        total++; if (we !== 1'b1 || wa !== 5'd3 || wd !== 32'hAA)
            begin bad++; $display("FAIL buffered_drain got=%0b/%0d/%0h want=1/3/aa", we, wa, wd); end
        total++; if (count !== 3'd0 || q_pending !== 1'b0)
            begin bad++; $display("FAIL buffered_after got=%0d/%0b want=0/0", count, q_pending); end
    endtask

    task automatic test_full_backpressure();
        for (int k = 1; k <= 4; k++) begin
            set_in(1, 20, 32'h0, 1, AW'(k), 32'hB0 + DW'(k), 0);
            step();
        end
        total++; if (full !== 1'b1 || m_ready !== 1'b0 || count !== 3'd4)
            begin bad++; $display("FAIL full_flags got=%0b/%0b/%0d want=1/0/4", full, m_ready, count); end
        set_in(1, 20, 32'h0, 1, 5, 32'hB5, 0);
        step();
        total++; if (count !== 3'd4)
            begin bad++; $display("FAIL full_held got=%0d want=4", count); end
        set_in(0, 0, 0, 1, 5, 32'hB5, 0);
        step();
        total++; if (we !== 1'b1 || wa !== 5'd1 || wd !== 32'hB1)
            begin bad++; $display("FAIL full_first_pop got=%0b/%0d/%0h want=1/1/b1", we, wa, wd); end
        total++; if (count !== 3'd3 || m_ready !== 1'b1 || full !== 1'b0)
            begin bad++; $display("FAIL full_release got=%0d/%0b/%0b want=3/1/0", count, m_ready, full); end
        set_in(1, 21, 32'h0, 1, 5, 32'hB5, 0);
        step();
        total++; if (count !== 3'd4)
            begin bad++; $display("FAIL full_accept_held got=%0d want=4", count); end
        set_in(0, 0, 0, 0, 0, 0, 0);
        for (int k = 2; k <= 5; k++) begin
            step();
            total++; if (we !== 1'b1 || wa !== AW'(k) || wd !== 32'hB0 + DW'(k))
                begin bad++; $display("FAIL full_drain got=%0b/%0d/%0h want=1/%0d/%0h", we, wa, wd, k, 32'hB0 + k); end
        end
    endtask

    task automatic test_squash_buffered();
        set_in(1, 20, 32'h0, 1, 7, 32'h77, 7);
        step();
        total++; if (q_pending !== 1'b1)
            begin bad++; $display("FAIL squash_pending_before got=%0b want=1", q_pending); end
        set_in(1, 7, 32'h55, 0, 0, 0, 7);
        step();
        total++; if (we !== 1'b1 || wa !== 5'd7 || wd !== 32'h55)
            begin bad++; $display("FAIL squash_write got=%0b/%0d/%0h want=1/7/55", we, wa, wd); end
        total++; if (q_pending !== 1'b0 || count !== 3'd1)
            begin bad++; $display("FAIL squash_killed got=%0b/%0d want=0/1", q_pending, count); end
        set_in(0, 0, 0, 0, 0, 0, 7);
        step();
        total++; if (we !== 1'b0 || count !== 3'd0 || wa !== 5'd7 || wd !== 32'h55)
            begin bad++; $display("FAIL squash_pop got=%0b/%0d/%0d/%0h want=0/0/7/55", we, count, wa, wd); end
    endtask

    task automatic test_same_cycle_kill();
        set_in(1, 9, 32'h99, 1, 9, 32'hCC, 9);
        step();
        total++; if (count !== 3'd1 || q_pending !== 1'b0)
            begin bad++; $display("FAIL samecyc_store got=%0d/%0b want=1/0", count, q_pending); end
        total++; if (we !== 1'b1 || wa !== 5'd9 || wd !== 32'h99)
            begin bad++; $display("FAIL samecyc_write got=%0b/%0d/%0h want=1/9/99", we, wa, wd); end
        set_in(0, 0, 0, 0, 0, 0, 9);
        step();
        total++; if (we !== 1'b0 || count !== 3'd0 || wd !== 32'h99)
            begin bad++; $display("FAIL samecyc_pop got=%0b/%0d/%0h want=0/0/99", we, count, wd); end
        set_in(0, 0, 0, 1, 0, 32'hDD, 0);
        #1;
        total++; if (m_ready !== 1'b1)
            begin bad++; $display("FAIL zero_dest_ready got=%0b want=1", m_ready); end
        step();
        total++; if (count !== 3'd0 || we !== 1'b0)
            begin bad++; $display("FAIL zero_dest_nostore got=%0d/%0b want=0/0", count, we); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            set_in(($urandom_range(0, 9) < 5), AW'($urandom_range(0, 7)), $urandom,
                   ($urandom_range(0, 9) < 5), AW'($urandom_range(0, 7)), $urandom,
                   AW'($urandom_range(0, 7)));
            #1;
            total++; if (m_ready !== (mq.size() < DEPTH))
                begin bad++; $display("FAIL rand_m_ready cyc=%0d got=%0b want=%0b", n, m_ready, mq.size() < DEPTH); end
            total++; if (q_pending !== model_pending(q_addr))
                begin bad++; $display("FAIL rand_q_pending cyc=%0d got=%0b want=%0b", n, q_pending, model_pending(q_addr)); end
            step();
            total++; if (we !== exp_we || wa !== exp_wa || wd !== exp_wd)
                begin bad++; $display("FAIL rand_write cyc=%0d got=%0b/%0d/%0h want=%0b/%0d/%0h", n, we, wa, wd, exp_we, exp_wa, exp_wd); end
            total++; if (count !== 3'(mq.size()) || full !== (mq.size() == DEPTH))
                begin bad++; $display("FAIL rand_count cyc=%0d got=%0d/%0b want=%0d/%0b", n, count, full, mq.size(), mq.size() == DEPTH); end
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        repeat (DEPTH + 1) step();
        total++; if (count !== 3'd0 || we !== exp_we || wa !== exp_wa || wd !== exp_wd)
            begin bad++; $display("FAIL rand_final got=%0d/%0b/%0d/%0h want=0/%0b/%0d/%0h", count, we, wa, wd, exp_we, exp_wa, exp_wd); end
    endtask

    task automatic test_reset_mid();
        for (int k = 1; k <= 3; k++) begin
            set_in(1, 12, 32'h1234, 1, AW'(k), 32'hC0 + DW'(k), 2);
            step();
        end
        total++; if (count !== 3'd3 || we !== 1'b1)
            begin bad++; $display("FAIL rstmid_pre got=%0d/%0b want=3/1", count, we); end
        #4;
        cpu_rst_n = 1'b0;
        #1;
        total++; if (we !== 1'b0 || wa !== '0 || wd !== '0 || count !== 3'd0)
            begin bad++; $display("FAIL rstmid_async got=%0b/%0d/%0h/%0d want=0/0/0/0", we, wa, wd, count); end
        total++; if (q_pending !== 1'b0)
            begin bad++; $display("FAIL rstmid_pending got=%0b want=0", q_pending); end
        @(posedge cpu_clk_50M);
        #3;
        set_in(0, 0, 0, 0, 0, 0, 2);
        cpu_rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 5; k++) begin
            step();
            total++; if (we !== 1'b0 || count !== 3'd0)
                begin bad++; $display("FAIL rstmid_after cyc=%0d got=%0b/%0d want=0/0", k, we, count); end
        end
    endtask

    initial begin
        cpu_rst_n = 1'b0;
        model_reset();
        do_reset();
        test_reset();
        test_pipe_write();
        test_buffer_behind_pipe();
        test_full_backpressure();
        test_squash_buffered();
        test_same_cycle_kill();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
